// File: rtl/posicionador_embarcacao.sv
// Ship-placement controller: turns debounced-free raw buttons into a bounded anchor/orientation
// and packs the occupied cells. Optional hold-to-repeat moves are enabled by `define AUTO_REPEAT_EN.
module posicionador_embarcacao #(
    parameter int TAMANHO       = 3,
    parameter int X_INICIAL     = 5,
    parameter int Y_INICIAL     = 5,
    parameter int REPEAT_CYCLES = 12500000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        leftArrow,
    input  logic        rightArrow,
    input  logic        upArrow,
    input  logic        downArrow,
    input  logic        rotacionar,
    input  logic        confirmar,
    input  logic        inicio,
    output logic [39:0] posicoesEmbarcacao,
    output logic        orientacao,
    output logic        ocupado,
    output logic        posicaoValida
);

    typedef enum logic [1:0] {OCIOSO, POSICIONANDO, CONFIRMADO} estadoT;

    localparam logic [4:0] SPAN = 5'(TAMANHO - 1);

    if (TAMANHO < 1 || TAMANHO > 5 || REPEAT_CYCLES < 1) begin : gParamInvalido
        $error("posicionador_embarcacao: illegal TAMANHO or REPEAT_CYCLES");
    end

    function automatic logic isOneHot(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

    // bit order: 0 left, 1 right, 2 up, 3 down, 4 rotate, 5 confirm
    logic [5:0] botoes_s;
    logic [5:0] sync1_r, sync2_r, nivel_r, borda_r;
    estadoT     estado_r;
    logic [3:0] ancoraX_r, ancoraY_r;
    logic       orientacao_r, ocupado_r, posicaoValida_r;
    logic [4:0] candX_s, candY_s, spanX_s, spanY_s;
    logic       moveOk_s, rotOk_s, umaDirecao_s, eventoDir_s;

    assign botoes_s = {confirmar, rotacionar, downArrow, upArrow, rightArrow, leftArrow};

    // Two-flop synchronizer, then a registered rising-edge pulse aligned with nivel_r
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_r <= 6'd0;
            sync2_r <= 6'd0;
            nivel_r <= 6'd0;
            borda_r <= 6'd0;
        end else begin
            sync1_r <= botoes_s;
            sync2_r <= sync1_r;
            nivel_r <= sync2_r;
            borda_r <= sync2_r & ~nivel_r;
        end
    end

    assign umaDirecao_s = isOneHot(nivel_r[3:0]);

`ifdef AUTO_REPEAT_EN
    localparam int CW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
    logic [CW-1:0] contador_r;
    logic          repeticao_s;

    assign repeticao_s = (estado_r == POSICIONANDO) && umaDirecao_s && (borda_r[3:0] == 4'd0) &&
                         (contador_r == CW'(REPEAT_CYCLES - 1));

    // Hold timer: any new direction edge, release, multi-press or leaving the state restarts it
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            contador_r <= '0;
        end else if ((estado_r != POSICIONANDO) || !umaDirecao_s || (borda_r[3:0] != 4'd0)) begin
            contador_r <= '0;
        end else if (contador_r == CW'(REPEAT_CYCLES - 1)) begin
            contador_r <= '0;
        end else begin
            contador_r <= contador_r + CW'(1);
        end
    end

    assign eventoDir_s = umaDirecao_s && ((borda_r[3:0] != 4'd0) || repeticao_s);
`else
    assign eventoDir_s = umaDirecao_s && (borda_r[3:0] != 4'd0);
`endif

    // Candidate anchor on 5-bit intermediates; 0-1 wraps to 31 and fails the <=9 test
    always_comb begin
        candX_s = {1'b0, ancoraX_r};
        candY_s = {1'b0, ancoraY_r};
        case (nivel_r[3:0])
            4'b0001: candX_s = {1'b0, ancoraX_r} - 5'd1;
            4'b0010: candX_s = {1'b0, ancoraX_r} + 5'd1;
            4'b0100: candY_s = {1'b0, ancoraY_r} + 5'd1;
            4'b1000: candY_s = {1'b0, ancoraY_r} - 5'd1;
            default: ;
        endcase
        if (orientacao_r) begin
            spanX_s = 5'd0;
            spanY_s = SPAN;
            rotOk_s = ({1'b0, ancoraX_r} + SPAN) <= 5'd9;
        end else begin
            spanX_s = SPAN;
            spanY_s = 5'd0;
            rotOk_s = ({1'b0, ancoraY_r} + SPAN) <= 5'd9;
        end
        moveOk_s = (candX_s <= 5'd9) && (candY_s <= 5'd9) &&
                   ((candX_s + spanX_s) <= 5'd9) && ((candY_s + spanY_s) <= 5'd9);
    end

    // Placement FSM with anchor, orientation and status outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_r        <= OCIOSO;
            ancoraX_r       <= 4'(X_INICIAL);
            ancoraY_r       <= 4'(Y_INICIAL);
            orientacao_r    <= 1'b0;
            ocupado_r       <= 1'b0;
            posicaoValida_r <= 1'b0;
        end else begin
            case (estado_r)
                OCIOSO: begin
                    posicaoValida_r <= 1'b0;
                    if (inicio) begin
                        ancoraX_r    <= 4'(X_INICIAL);
                        ancoraY_r    <= 4'(Y_INICIAL);
                        orientacao_r <= 1'b0;
                        ocupado_r    <= 1'b1;
                        estado_r     <= POSICIONANDO;
                    end
                end
                POSICIONANDO: begin
                    if (borda_r[5]) begin
                        ocupado_r       <= 1'b0;
                        posicaoValida_r <= 1'b1;
                        estado_r        <= CONFIRMADO;
                    end else if (borda_r[4]) begin
                        if (rotOk_s) begin
                            orientacao_r <= ~orientacao_r;
                        end
                    end else if (eventoDir_s && moveOk_s) begin
                        ancoraX_r <= candX_s[3:0];
                        ancoraY_r <= candY_s[3:0];
                    end
                end
                CONFIRMADO: begin
                    posicaoValida_r <= 1'b0;
                    estado_r        <= OCIOSO;
                end
                default: begin
                    ocupado_r       <= 1'b0;
                    posicaoValida_r <= 1'b0;
                    estado_r        <= OCIOSO;
                end
            endcase
        end
    end

    // Cell packing straight from the registered anchor; unused cells read FF
    always_comb begin
        posicoesEmbarcacao = {40{1'b1}};
        for (int i = 0; i < 5; i++) begin
            if (i < TAMANHO) begin
                if (orientacao_r) begin
                    posicoesEmbarcacao[8*i +: 8] = {ancoraY_r + 4'(i), ancoraX_r};
                end else begin
                    posicoesEmbarcacao[8*i +: 8] = {ancoraY_r, ancoraX_r + 4'(i)};
                end
            end else begin
                posicoesEmbarcacao[8*i +: 8] = 8'hFF;
            end
        end
    end

    assign orientacao    = orientacao_r;
    assign ocupado       = ocupado_r;
    assign posicaoValida = posicaoValida_r;

endmodule
